// File: rtl/inst_sram_bridge_pkg.sv
// Shared constants, state encoding and address helper for the IF-stage instruction-SRAM to AXI4 read bridge.
package inst_sram_bridge_pkg;

   localparam logic [3:0]  ARID           = 4'd0;
   localparam logic [31:0] PADDR_MASK     = 32'h1FFF_FFFF;
   localparam logic [7:0]  AXI_LEN_1BEAT  = 8'd0;
   localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } fetch_state_e;

   // kseg0/kseg1 fold down to the same physical window; fetches are always word aligned.
   function automatic logic [31:0] phys_addr(input logic [31:0] va);
      return va & PADDR_MASK & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/inst_sram_bridge_dffre.sv
// Generic data register with asynchronous active-low reset and load enable.
module DFFRE #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_o <= RESET_VAL;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/inst_sram_bridge.sv
// Services IF-stage fetch requests as single-beat AXI4 reads, one outstanding at a time.
// Optional one-entry fetch buffer enabled by defining INST_BUF_EN.
module inst_sram_bridge
   import inst_sram_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   input  logic        cancel_i,
   output logic [31:0] inst_sram_rdata,
   output logic        if_stallreq_o,
   output logic        bus_err_o,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   fetch_state_e state_q, state_d;
   logic         drop_q, drop_d;

   logic [31:0]  req_addr_q, req_addr_d, req_addr_nx_q;
   logic         req_addr_en, req_addr_nx_en;
   logic [31:0]  rdata_q, rdata_d;
   logic         rdata_en;
   logic         bus_err_q, bus_err_d;

   logic         accept, beat, discard, capture, resp_ok;
   logic         buf_hit;
   logic [31:0]  buf_word;

   // Write data, read ID and RLAST carry no information with a single read in flight.
   logic         unused_ok;
   assign unused_ok = ^{inst_sram_wdata, rid, rlast};

   assign accept  = (state_q == ST_IDLE || state_q == ST_DONE) && inst_sram_en
                    && (inst_sram_wen == 4'h0);
   assign beat    = (state_q == ST_DATA) && rvalid;
   assign discard = beat && (drop_q || cancel_i);
   assign capture = beat && !discard;
   assign resp_ok = (rresp == AXI_RESP_OKAY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      req_addr_en = 1'b0;
      req_addr_d  = inst_sram_addr;
      rdata_en    = 1'b0;
      rdata_d     = resp_ok ? rdata : 32'h0;
      bus_err_d   = !resp_ok;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               req_addr_en = 1'b1;
               if (buf_hit) begin
                  state_d   = ST_DONE;
                  rdata_en  = 1'b1;
                  rdata_d   = buf_word;
                  bus_err_d = 1'b0;
               end else begin
                  state_d = ST_ADDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (cancel_i) begin
               drop_d = 1'b1;
            end
            if (arready) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // A cancel arriving with the beat retargets straight to the new address.
            if (discard) begin
               drop_d      = 1'b0;
               req_addr_en = 1'b1;
               req_addr_d  = cancel_i ? inst_sram_addr : req_addr_nx_q;
               state_d     = ST_ADDR;
            end else if (capture) begin
               rdata_en = 1'b1;
               state_d  = ST_DONE;
            end else if (cancel_i) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_addr_nx_en = cancel_i && (state_q == ST_ADDR || state_q == ST_DATA);

   DFFRE #(.WIDTH(32)) u_req_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (req_addr_en),
      .d_i   (req_addr_d),
      .q_o   (req_addr_q)
   );

   DFFRE #(.WIDTH(32)) u_req_addr_nx (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (req_addr_nx_en),
      .d_i   (inst_sram_addr),
      .q_o   (req_addr_nx_q)
   );

   DFFRE #(.WIDTH(32)) u_rdata (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (rdata_en),
      .d_i   (rdata_d),
      .q_o   (rdata_q)
   );

   DFFRE #(.WIDTH(1)) u_bus_err (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (rdata_en),
      .d_i   (bus_err_d),
      .q_o   (bus_err_q)
   );

`ifdef INST_BUF_EN
   logic        buf_valid_q;
   logic [31:0] buf_tag_q, buf_word_q;
   logic        buf_fill;

   assign buf_fill = capture && resp_ok;

   // Any cancel or error response leaves the buffer empty.
   DFFRE #(.WIDTH(1)) u_buf_valid (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (cancel_i || capture),
      .d_i   (!cancel_i && resp_ok),
      .q_o   (buf_valid_q)
   );

   DFFRE #(.WIDTH(32)) u_buf_tag (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (buf_fill),
      .d_i   (phys_addr(req_addr_q)),
      .q_o   (buf_tag_q)
   );

   DFFRE #(.WIDTH(32)) u_buf_word (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (buf_fill),
      .d_i   (rdata),
      .q_o   (buf_word_q)
   );

   assign buf_hit  = buf_valid_q && !cancel_i && (buf_tag_q == phys_addr(inst_sram_addr));
   assign buf_word = buf_word_q;
`else
   assign buf_hit  = 1'b0;
   assign buf_word = 32'h0;
`endif

   assign arvalid         = (state_q == ST_ADDR);
   assign araddr          = phys_addr(req_addr_q);
   assign arid            = ARID;
   assign arlen           = AXI_LEN_1BEAT;
   assign arsize          = AXI_SIZE_4B;
   assign arburst         = AXI_BURST_INCR;
   assign rready          = (state_q == ST_DATA);
   assign inst_sram_rdata = rdata_q;
   assign bus_err_o       = bus_err_q;
   assign if_stallreq_o   = (state_q == ST_ADDR) || (state_q == ST_DATA) || drop_q;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed self-checking bench for inst_sram_bridge; expected fetch words flow through a scoreboard queue.
module tb_inst_sram_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        cancel_i;
   logic [31:0] inst_sram_rdata;
   logic        if_stallreq_o;
   logic        bus_err_o;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] expQ[$];
   logic [31:0] held = 32'h0;

   always #5 clk = ~clk;

   inst_sram_bridge dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .cancel_i        (cancel_i),
      .inst_sram_rdata (inst_sram_rdata),
      .if_stallreq_o   (if_stallreq_o),
      .bus_err_o       (bus_err_o),
      .arid            (arid),
      .araddr          (araddr),
      .arlen           (arlen),
      .arsize          (arsize),
      .arburst         (arburst),
      .arvalid         (arvalid),
      .arready         (arready),
      .rid             (rid),
      .rdata           (rdata),
      .rresp           (rresp),
      .rlast           (rlast),
      .rvalid          (rvalid),
      .rready          (rready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic cancel);
      inst_sram_en   = en;
      inst_sram_wen  = wen;
      inst_sram_addr = addr;
      cancel_i       = cancel;
   endtask

   task automatic slave(input logic ar, input logic rv, input logic [31:0] d, input logic [1:0] resp);
      arready = ar;
      rvalid  = rv;
      rdata   = d;
      rresp   = resp;
   endtask

   task automatic nextCycle;
      @(negedge clk);
   endtask

   // DONE cycle: stall released and the oldest expected word is on rdata.
   task automatic checkDone(input string tag);
      checkOutput({tag, "_stall"}, 32'(if_stallreq_o), 32'h0);
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_scoreboard: observed=empty expected=entry", tag);
      end else begin
         held = expQ.pop_front();
         checkOutput({tag, "_rdata"}, inst_sram_rdata, held);
      end
   endtask

   // Full fetch with arready=1 and the beat in the first DATA cycle; returns in the DONE cycle.
   task automatic runFetch(input string tag, input logic [31:0] addr, input logic [31:0] expAraddr,
                           input logic [31:0] word, input logic [1:0] resp);
      applyStimulus(1'b1, 4'h0, addr, 1'b0);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput({tag, "_arvalid"}, 32'(arvalid), 32'h1);
      checkOutput({tag, "_araddr"}, araddr, expAraddr);
      checkOutput({tag, "_stall_addr"}, 32'(if_stallreq_o), 32'h1);
      applyStimulus(1'b0, 4'h0, addr, 1'b0);
      nextCycle();
      checkOutput({tag, "_rready"}, 32'(rready), 32'h1);
      slave(1'b1, 1'b1, word, resp);
      expQ.push_back((resp == 2'b00) ? word : 32'h0);
      nextCycle();
      checkDone(tag);
      checkOutput({tag, "_bus_err"}, 32'(bus_err_o), (resp == 2'b00) ? 32'h0 : 32'h1);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
   endtask

   initial begin
      rst_n           = 1'b0;
      inst_sram_wdata = 32'h0;
      rid             = 4'h0;
      rlast           = 1'b1;
      applyStimulus(1'b1, 4'h0, 32'hBFC0_0000, 1'b0);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      repeat (2) nextCycle();

      checkOutput("rst_arvalid", 32'(arvalid), 32'h0);
      checkOutput("rst_rready", 32'(rready), 32'h0);
      checkOutput("rst_araddr", araddr, 32'h0);
      checkOutput("rst_rdata", inst_sram_rdata, 32'h0);
      checkOutput("rst_bus_err", 32'(bus_err_o), 32'h0);
      checkOutput("rst_stall", 32'(if_stallreq_o), 32'h0);

      // Reset vector fetch with the request already pending out of reset.
      rst_n = 1'b1;
      nextCycle();
      checkOutput("t1_arvalid", 32'(arvalid), 32'h1);
      checkOutput("t1_araddr", araddr, 32'h1FC0_0000);
      checkOutput("t1_stall_c1", 32'(if_stallreq_o), 32'h1);
      checkOutput("t1_rready_c1", 32'(rready), 32'h0);
      checkOutput("t1_arid", 32'(arid), 32'h0);
      checkOutput("t1_arlen", 32'(arlen), 32'h0);
      checkOutput("t1_arsize", 32'(arsize), 32'h2);
      checkOutput("t1_arburst", 32'(arburst), 32'h1);
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0000, 1'b0);
      nextCycle();
      checkOutput("t1_rready_c2", 32'(rready), 32'h1);
      checkOutput("t1_arvalid_c2", 32'(arvalid), 32'h0);
      checkOutput("t1_stall_c2", 32'(if_stallreq_o), 32'h1);
      slave(1'b1, 1'b1, 32'h2408_0001, 2'b00);
      expQ.push_back(32'h2408_0001);
      nextCycle();
      checkDone("t1");
      checkOutput("t1_bus_err", 32'(bus_err_o), 32'h0);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput("t1_hold_rdata", inst_sram_rdata, held);
      checkOutput("t1_idle_stall", 32'(if_stallreq_o), 32'h0);

      // AR back-pressure.
      applyStimulus(1'b1, 4'h0, 32'hBFC0_0004, 1'b0);
      slave(1'b0, 1'b0, 32'h0, 2'b00);
      nextCycle();
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0004, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t2_arvalid", 32'(arvalid), 32'h1);
         checkOutput("t2_araddr", araddr, 32'h1FC0_0004);
         checkOutput("t2_stall", 32'(if_stallreq_o), 32'h1);
         checkOutput("t2_rready", 32'(rready), 32'h0);
         nextCycle();
      end
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput("t2_rready_data", 32'(rready), 32'h1);
      slave(1'b1, 1'b1, 32'h3C1D_8000, 2'b00);
      expQ.push_back(32'h3C1D_8000);
      nextCycle();
      checkDone("t2");
      slave(1'b1, 1'b0, 32'h0, 2'b00);

      // Cancel in DATA ahead of the stale beat.
      applyStimulus(1'b1, 4'h0, 32'hBFC0_0008, 1'b0);
      nextCycle();
      checkOutput("t3a_araddr", araddr, 32'h1FC0_0008);
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0008, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'h0, 32'h8000_0180, 1'b1);
      nextCycle();
      checkOutput("t3a_rready_drop", 32'(rready), 32'h1);
      checkOutput("t3a_stall_drop", 32'(if_stallreq_o), 32'h1);
      applyStimulus(1'b0, 4'h0, 32'h8000_0180, 1'b0);
      slave(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00);
      nextCycle();
      checkOutput("t3a_arvalid_retry", 32'(arvalid), 32'h1);
      checkOutput("t3a_araddr_retry", araddr, 32'h0000_0180);
      checkOutput("t3a_stall_retry", 32'(if_stallreq_o), 32'h1);
      checkOutput("t3a_rdata_kept", inst_sram_rdata, held);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput("t3a_stall_data", 32'(if_stallreq_o), 32'h1);
      slave(1'b1, 1'b1, 32'h1000_FFFF, 2'b00);
      expQ.push_back(32'h1000_FFFF);
      nextCycle();
      checkDone("t3a");
      slave(1'b1, 1'b0, 32'h0, 2'b00);

      // Cancel coinciding with the beat.
      applyStimulus(1'b1, 4'h0, 32'hBFC0_000C, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'h0, 32'hBFC0_000C, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0020, 1'b1);
      slave(1'b1, 1'b1, 32'hBAD0_BAD0, 2'b00);
      nextCycle();
      checkOutput("t3b_arvalid", 32'(arvalid), 32'h1);
      checkOutput("t3b_araddr", araddr, 32'h1FC0_0020);
      checkOutput("t3b_rdata_kept", inst_sram_rdata, held);
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0020, 1'b0);
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      slave(1'b1, 1'b1, 32'h8C82_0004, 2'b00);
      expQ.push_back(32'h8C82_0004);
      nextCycle();
      checkDone("t3b");
      slave(1'b1, 1'b0, 32'h0, 2'b00);

      // Error response, then recovery.
      runFetch("t4_err", 32'hBFC0_0024, 32'h1FC0_0024, 32'h1234_5678, 2'b10);
      runFetch("t4_ok", 32'hBFC0_0028, 32'h1FC0_0028, 32'hAFBF_0014, 2'b00);

      // Write requests are ignored.
      applyStimulus(1'b1, 4'hF, 32'hBFC0_0030, 1'b0);
      for (int i = 0; i < 10; i++) begin
         nextCycle();
         checkOutput("t5_arvalid", 32'(arvalid), 32'h0);
         checkOutput("t5_stall", 32'(if_stallreq_o), 32'h0);
      end
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0030, 1'b0);
      nextCycle();

      // Asynchronous reset in the middle of a fetch.
      applyStimulus(1'b1, 4'h0, 32'hBFC0_0040, 1'b0);
      slave(1'b0, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput("t6_arvalid_pre", 32'(arvalid), 32'h1);
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0040, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t6_arvalid_rst", 32'(arvalid), 32'h0);
      checkOutput("t6_stall_rst", 32'(if_stallreq_o), 32'h0);
      checkOutput("t6_araddr_rst", araddr, 32'h0);
      checkOutput("t6_rdata_rst", inst_sram_rdata, 32'h0);
      #1 rst_n = 1'b1;
      slave(1'b1, 1'b0, 32'h0, 2'b00);
      nextCycle();
      checkOutput("t6_arvalid_idle", 32'(arvalid), 32'h0);

`ifdef INST_BUF_EN
      runFetch("t7_first", 32'hBFC0_0010, 32'h1FC0_0010, 32'h27BD_FFE8, 2'b00);
      applyStimulus(1'b1, 4'h0, 32'hBFC0_0010, 1'b0);
      expQ.push_back(32'h27BD_FFE8);
      nextCycle();
      checkOutput("t7_hit_arvalid", 32'(arvalid), 32'h0);
      checkDone("t7_hit");
      checkOutput("t7_hit_bus_err", 32'(bus_err_o), 32'h0);
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0010, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 4'h0, 32'hBFC0_0010, 1'b0);
      runFetch("t7_after_cancel", 32'hBFC0_0010, 32'h1FC0_0010, 32'h27BD_FFE8, 2'b00);
`else
      runFetch("t7_first", 32'hBFC0_0010, 32'h1FC0_0010, 32'h27BD_FFE8, 2'b00);
      runFetch("t7_repeat", 32'hBFC0_0010, 32'h1FC0_0010, 32'h27BD_FFE8, 2'b00);
`endif
      applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
      nextCycle();

      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
